mdu: RTL

- Multiply/divide unit in the EX stage of the P6 pipelined MIPS core.
- Sits beside the ALU and takes the same forwarded operands A (rs) and B (rt).
- Executes mult/multu/div/divu over multiple cycles and owns the HI/LO registers. mthi/mtlo write those registers directly.
- HI/LO feed the EX result mux for mfhi/mflo. Busy feeds the hazard unit, which stalls md-class instructions in D while an operation is in flight.

---
 rtl/mdu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the EX stage of the P6 MIPS core.
// Owns HI/LO. mult/multu/div/divu run for a fixed number of busy cycles and
// commit their result on the last busy edge; mthi/mtlo write HI/LO at once.
// The result is formed combinationally from the latched operands and only
// reaches HI/LO at the final busy edge, so intermediate cycles never expose it.

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    // Latched operation, operands and remaining busy cycles.
    logic signed [31:0] a_p0;
    logic signed [31:0] b_p0;
    logic [3:0]         op_p0;
    logic [3:0]         cnt_p0;

    // Result derived from the latched operands, committed when cnt_p0 hits 1.
    logic [63:0]        res_p0;
    logic               wr_p0;

    // Full 64-bit two's-complement product.
    function automatic logic [63:0] mul_signed(input logic signed [31:0] x,
                                               input logic signed [31:0] y);
        logic signed [63:0] xe;
        logic signed [63:0] ye;
        xe = {{32{x[31]}}, x};
        ye = {{32{y[31]}}, y};
        return xe * ye;
    endfunction

    // Full 64-bit unsigned product.
    function automatic logic [63:0] mul_unsigned(input logic [31:0] x,
                                                 input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Signed divide on magnitudes: quotient truncates toward zero, remainder
    // follows the dividend. Working on magnitudes makes 0x80000000 / -1 wrap
    // to 0x80000000 with a zero remainder instead of overflowing.
    // Returns {remainder, quotient}.
    function automatic logic [63:0] div_signed(input logic signed [31:0] x,
                                               input logic signed [31:0] y);
        logic [31:0] ux;
        logic [31:0] uy;
        logic [31:0] uq;
        logic [31:0] ur;
        logic [31:0] quo;
        logic [31:0] rem;
        ux  = x[31] ? (32'd0 - x) : x;
        uy  = y[31] ? (32'd0 - y) : y;
        uq  = ux / uy;
        ur  = ux % uy;
        quo = (x[31] ^ y[31]) ? (32'd0 - uq) : uq;
        rem = x[31] ? (32'd0 - ur) : ur;
        return {rem, quo};
    endfunction

    // Unsigned divide, returns {remainder, quotient}.
    function automatic logic [63:0] div_unsigned(input logic [31:0] x,
                                                 input logic [31:0] y);
        return {x % y, x / y};
    endfunction

    // Result selection; divide by zero suppresses the HI/LO write.
    always_comb begin
        res_p0 = 64'd0;
        wr_p0  = 1'b0;
        case (op_p0)
            OP_MULT: begin
                res_p0 = mul_signed(a_p0, b_p0);
                wr_p0  = 1'b1;
            end
            OP_MULTU: begin
                res_p0 = mul_unsigned($unsigned(a_p0), $unsigned(b_p0));
                wr_p0  = 1'b1;
            end
            OP_DIV: begin
                res_p0 = div_signed(a_p0, b_p0);
                wr_p0  = (b_p0 != 32'sd0);
            end
            OP_DIVU: begin
                res_p0 = div_unsigned($unsigned(a_p0), $unsigned(b_p0));
                wr_p0  = (b_p0 != 32'sd0);
            end
            default: ;
        endcase
    end

    // --- stage boundary: accept / count down / commit into HI, LO ---
    // Busy and the counter gate everything; Start is only looked at when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            Busy   <= 1'b0;
            cnt_p0 <= 4'd0;
            a_p0   <= '0;
            b_p0   <= '0;
            op_p0  <= OP_NONE;
            HI     <= '0;
            LO     <= '0;
        end else if (Busy) begin
            if (cnt_p0 == 4'd1) begin
                Busy   <= 1'b0;
                cnt_p0 <= 4'd0;
                if (wr_p0) begin
                    HI <= res_p0[63:32];
                    LO <= res_p0[31:0];
                end
            end else begin
                cnt_p0 <= cnt_p0 - 4'd1;
            end
        end else if (Start) begin
            case (MDOp)
                OP_MULT, OP_MULTU: begin
                    a_p0   <= A;
                    b_p0   <= B;
                    op_p0  <= MDOp;
                    cnt_p0 <= MULT_LOAD;
                    Busy   <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    a_p0   <= A;
                    b_p0   <= B;
                    op_p0  <= MDOp;
                    cnt_p0 <= DIV_LOAD;
                    Busy   <= 1'b1;
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule
